// File: rtl/fp_to_fp_pipe.sv
// Pipelined FCVT.S.D / FCVT.D.S converter with IEEE-754 flags, valid/ready
// handshakes, flush and an opaque tag. Stage 0 unpacks, the last stage rounds/packs.
module fp_to_fp_pipe #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [63:0]      io_in_bits_src,
  input  logic             io_in_bits_typ,
  input  logic [2:0]       io_in_bits_rm,
  input  logic [TAG_W-1:0] io_in_bits_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [63:0]      io_out_bits_result,
  output logic [4:0]       io_out_bits_fflags,
  output logic [TAG_W-1:0] io_out_bits_tag
);

  typedef struct packed {
    logic        typ;
    logic [2:0]  rm;
    logic        sign;
    logic        nan;
    logic        snan;
    logic        inf;
    logic        zero;
    logic [12:0] expo;
    logic [52:0] sig;
  } unp_t;

  logic [LATENCY-1:0] valid_r;
  logic [LATENCY-1:0] adv_s;
  logic [TAG_W-1:0]   tag_r [LATENCY];
  logic [63:0]        res_r;
  logic [4:0]         flags_r;

  function automatic logic [5:0] msb_pos(input logic [51:0] v);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 0; i < 52; i++) begin
      p = v[i] ? 6'(i) : p;
    end
    return p;
  endfunction

  // Finite non-zero operands leave here as 1.sig * 2^expo with sig[52] set.
  function automatic unp_t unpack_op(input logic [63:0] src, input logic typ, input logic [2:0] rm);
    unp_t       u;
    logic [5:0] p;
    u      = '0;
    u.typ  = typ;
    u.rm   = rm;
    p      = typ ? msb_pos({29'd0, src[22:0]}) : msb_pos(src[51:0]);
    if (!typ) begin
      u.sign = src[63];
      if (src[62:52] == 11'h7ff) begin
        u.inf  = (src[51:0] == 52'd0);
        u.nan  = (src[51:0] != 52'd0);
        u.snan = (src[51:0] != 52'd0) && !src[51];
      end else if (src[62:52] == 11'd0) begin
        u.zero = (src[51:0] == 52'd0);
        u.expo = 13'($signed({7'd0, p}) - 13'sd1074);
        u.sig  = {1'b0, src[51:0]} << (6'd52 - p);
      end else begin
        u.expo = 13'($signed({2'd0, src[62:52]}) - 13'sd1023);
        u.sig  = {1'b1, src[51:0]};
      end
    end else if (src[63:32] != 32'hffff_ffff) begin
      u.nan = 1'b1;
    end else begin
      u.sign = src[31];
      if (src[30:23] == 8'hff) begin
        u.inf  = (src[22:0] == 23'd0);
        u.nan  = (src[22:0] != 23'd0);
        u.snan = (src[22:0] != 23'd0) && !src[22];
      end else if (src[30:23] == 8'd0) begin
        u.zero = (src[22:0] == 23'd0);
        u.expo = 13'($signed({7'd0, p}) - 13'sd149);
        u.sig  = {30'd0, src[22:0]} << (6'd52 - p);
      end else begin
        u.expo = 13'($signed({5'd0, src[30:23]}) - 13'sd127);
        u.sig  = {1'b1, src[22:0], 29'd0};
      end
    end
    return u;
  endfunction

  // Returns {result, fflags}; tininess is judged on the rounded single result.
  function automatic logic [68:0] round_pack(input unp_t u);
    logic signed [12:0] e_s;
    logic signed [12:0] sh_full;
    logic signed [12:0] exp_r;
    logic [5:0]         sh;
    logic [63:0]        ext;
    logic [63:0]        shifted;
    logic               lost;
    logic               guard;
    logic               sticky;
    logic               inexact;
    logic               inc;
    logic               ovf;
    logic               tiny;
    logic               max_fin;
    logic [24:0]        mant;
    logic [7:0]         biased;
    logic [63:0]        res;
    logic [4:0]         flags;
    e_s     = $signed(u.expo);
    sh_full = -13'sd126 - e_s;
    if (e_s < -13'sd126) begin
      sh = (sh_full > 13'sd63) ? 6'd63 : sh_full[5:0];
    end else begin
      sh = 6'd0;
    end
    ext     = {u.sig, 11'd0};
    shifted = ext >> sh;
    lost    = |(ext & ((64'd1 << sh) - 64'd1));
    guard   = shifted[39];
    sticky  = (|shifted[38:0]) | lost;
    inexact = guard | sticky;
    case (u.rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = u.sign & inexact;
      3'd3:    inc = !u.sign & inexact;
      3'd4:    inc = guard;
      default: inc = guard & (sticky | shifted[40]);
    endcase
    mant    = {1'b0, shifted[63:40]} + {24'd0, inc};
    exp_r   = e_s + $signed({12'd0, mant[24]});
    biased  = (sh != 6'd0) ? {7'd0, mant[23]} : 8'(exp_r + 13'sd127);
    ovf     = (sh == 6'd0) && (exp_r > 13'sd127);
    tiny    = (sh != 6'd0) && !mant[23];
    max_fin = (u.rm == 3'd1) || ((u.rm == 3'd2) && !u.sign) || ((u.rm == 3'd3) && u.sign);
    if (u.typ) begin
      flags = 5'd0;
      if (u.nan) begin
        res   = 64'h7ff8_0000_0000_0000;
        flags = {u.snan, 4'd0};
      end else if (u.inf) begin
        res = {u.sign, 11'h7ff, 52'd0};
      end else if (u.zero) begin
        res = {u.sign, 63'd0};
      end else begin
        res = {u.sign, 11'(e_s + 13'sd1023), u.sig[51:0]};
      end
    end else if (u.nan) begin
      res   = {32'hffff_ffff, 32'h7fc0_0000};
      flags = {u.snan, 4'd0};
    end else if (u.inf) begin
      res   = {32'hffff_ffff, u.sign, 31'h7f80_0000};
      flags = 5'd0;
    end else if (u.zero) begin
      res   = {32'hffff_ffff, u.sign, 31'd0};
      flags = 5'd0;
    end else if (ovf) begin
      res   = {32'hffff_ffff, u.sign, max_fin ? 31'h7f7f_ffff : 31'h7f80_0000};
      flags = 5'b00101;
    end else begin
      res   = {32'hffff_ffff, u.sign, biased, mant[22:0]};
      flags = {3'd0, tiny & inexact, inexact};
    end
    return {res, flags};
  endfunction

  // Stage k moves when some stage at or after it is empty, or the consumer takes the output.
  for (genvar k = 0; k < LATENCY; k++) begin : g_adv
    assign adv_s[k] = io_out_ready || !(&valid_r[LATENCY-1:k]);
  end

  assign io_in_ready        = adv_s[0];
  assign io_out_valid       = valid_r[LATENCY-1];
  assign io_out_bits_result = res_r;
  assign io_out_bits_fflags = flags_r;
  assign io_out_bits_tag    = tag_r[LATENCY-1];

  // Stage valid bits; flush wins over advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (io_flush) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= adv_s[0] ? io_in_valid : valid_r[0];
      for (int k = 1; k < LATENCY; k++) begin
        valid_r[k] <= adv_s[k] ? valid_r[k-1] : valid_r[k];
      end
    end
  end

  // Tag sideband follows its operation stage by stage.
  always_ff @(posedge clock) begin
    if (adv_s[0]) begin
      tag_r[0] <= io_in_bits_tag;
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (adv_s[k]) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_single
    // Unpack, round and pack in one cycle.
    always_ff @(posedge clock) begin
      if (adv_s[0]) begin
        {res_r, flags_r} <= round_pack(unpack_op(io_in_bits_src, io_in_bits_typ, io_in_bits_rm));
      end
    end
  end else begin : g_multi
    unp_t unp_r [LATENCY-1];
    // Unpacked operands travel through the middle stages; the last stage rounds.
    always_ff @(posedge clock) begin
      if (adv_s[0]) begin
        unp_r[0] <= unpack_op(io_in_bits_src, io_in_bits_typ, io_in_bits_rm);
      end
      for (int k = 1; k < LATENCY - 1; k++) begin
        if (adv_s[k]) begin
          unp_r[k] <= unp_r[k-1];
        end
      end
      if (adv_s[LATENCY-1]) begin
        {res_r, flags_r} <= round_pack(unp_r[LATENCY-2]);
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fp_pipe.sv
// Randomised bench for fp_to_fp_pipe: integer-arithmetic reference model,
// scoreboard, directed corner vectors, backpressure, flush and async reset.
module tb_fp_to_fp_pipe;
  localparam int LAT = 2;
  localparam int TW  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_flush;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [63:0]   io_in_bits_src;
  logic          io_in_bits_typ;
  logic [2:0]    io_in_bits_rm;
  logic [TW-1:0] io_in_bits_tag;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [63:0]   io_out_bits_result;
  logic [4:0]    io_out_bits_fflags;
  logic [TW-1:0] io_out_bits_tag;

  fp_to_fp_pipe #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_src(io_in_bits_src), .io_in_bits_typ(io_in_bits_typ),
    .io_in_bits_rm(io_in_bits_rm), .io_in_bits_tag(io_in_bits_tag),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_result(io_out_bits_result), .io_out_bits_fflags(io_out_bits_fflags),
    .io_out_bits_tag(io_out_bits_tag)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [76:0]   exp_q [$];
  logic [TW-1:0] out_log [$];
  logic          hold_pending = 1'b0;
  logic [76:0]   held;

  task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Double -> single: value = m * 2^ex, rounded to a quantum of 2^q with integer arithmetic.
  function automatic logic [68:0] ref_d2s(input logic [63:0] src, input logic [2:0] rm);
    logic s;
    int e, ex, msb, q, d, cmp;
    logic [51:0] f;
    longint unsigned m, quo, rem, half;
    bit up, nx;
    logic [31:0] r;
    logic [4:0] fl;
    s = src[63]; e = int'(src[62:52]); f = src[51:0];
    if (e == 2047) begin
      if (f != 52'd0) return {32'hffffffff, 32'h7fc00000, !f[51], 4'd0};
      return {32'hffffffff, s, 31'h7f800000, 5'd0};
    end
    if (e == 0 && f == 52'd0) return {32'hffffffff, s, 31'd0, 5'd0};
    m  = (e == 0) ? 64'(f) : ((64'd1 << 52) | 64'(f));
    ex = (e == 0) ? -1074 : e - 1075;
    msb = 0;
    for (int i = 0; i < 53; i++) if (m[i]) msb = i;
    q = msb + ex - 23;
    if (q < -149) q = -149;
    d = q - ex;
    if (d > 60) begin
      quo = 0; rem = m; cmp = -1;
    end else begin
      quo  = m >> d;
      rem  = m - (quo << d);
      half = 64'd1 << (d - 1);
      cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
    end
    nx = (rem != 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && nx;
      3'd3:    up = !s && nx;
      3'd4:    up = (cmp >= 0);
      default: up = (cmp > 0) || (cmp == 0 && quo[0]);
    endcase
    quo = quo + longint'(up);
    if (quo == (64'd1 << 24)) begin
      quo = 64'd1 << 23; q = q + 1;
    end
    if (quo >= (64'd1 << 23) && q > 104) begin
      r = (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) ? {s, 31'h7f7fffff} : {s, 31'h7f800000};
      return {32'hffffffff, r, 5'b00101};
    end
    if (quo < (64'd1 << 23)) begin
      r = {s, 8'd0, quo[22:0]}; fl = nx ? 5'b00011 : 5'd0;
    end else begin
      r = {s, 8'(q + 150), quo[22:0]}; fl = nx ? 5'b00001 : 5'd0;
    end
    return {32'hffffffff, r, fl};
  endfunction

  function automatic logic [68:0] ref_s2d(input logic [63:0] src);
    logic s;
    int e, p;
    logic [22:0] f;
    longint unsigned fr;
    if (src[63:32] != 32'hffffffff) return {64'h7ff8000000000000, 5'd0};
    s = src[31]; e = int'(src[30:23]); f = src[22:0];
    if (e == 255) begin
      if (f != 23'd0) return {64'h7ff8000000000000, !f[22], 4'd0};
      return {s, 11'h7ff, 52'd0, 5'd0};
    end
    if (e == 0 && f == 23'd0) return {s, 63'd0, 5'd0};
    if (e == 0) begin
      p = 0;
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      fr = (64'(f) << (52 - p)) & ((64'd1 << 52) - 64'd1);
      return {s, 11'(p - 149 + 1023), fr[51:0], 5'd0};
    end
    return {s, 11'(e - 127 + 1023), f, 29'd0, 5'd0};
  endfunction

  function automatic logic [63:0] rand_d();
    logic [63:0] w;
    logic [51:0] m;
    int e;
    w = {$urandom, $urandom};
    m = w[51:0];
    case ($urandom_range(0, 9))
      0: begin e = 2047; if ($urandom_range(0, 1) == 0) m = '0; end
      1: e = 0;
      2, 3: e = 1023 + int'($urandom_range(124, 129));
      4, 5: e = 1023 - int'($urandom_range(124, 152));
      default: e = int'($urandom_range(1023 - 126, 1023 + 127));
    endcase
    if ($urandom_range(0, 3) == 0) m[28:0] = {1'b1, 28'd0};
    else if ($urandom_range(0, 7) == 0) m[28:0] = '1;
    return {w[63], 11'(e), m};
  endfunction

  function automatic logic [63:0] rand_s();
    logic [31:0] w;
    logic [31:0] hi;
    int e;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: e = 255;
      1: e = 0;
      default: e = int'($urandom_range(1, 254));
    endcase
    hi = ($urandom_range(0, 9) == 0) ? $urandom : 32'hffffffff;
    return {hi, w[31], 8'(e), w[22:0]};
  endfunction

  // Scoreboard: outputs checked in FIFO order; held outputs must not move.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check_value("hold_stable", 80'({io_out_bits_result, io_out_bits_fflags, io_out_bits_tag}), 80'(held));
      if (io_out_valid && io_out_ready) begin
        check_value("out_expected", 80'(exp_q.size() != 0), 80'(1));
        if (exp_q.size() != 0)
          check_value("result", 80'({io_out_bits_result, io_out_bits_fflags, io_out_bits_tag}), 80'(exp_q.pop_front()));
        out_log.push_back(io_out_bits_tag);
      end
      hold_pending = io_out_valid && !io_out_ready && !io_flush;
      held = {io_out_bits_result, io_out_bits_fflags, io_out_bits_tag};
      if (io_flush) exp_q.delete();
      else if (io_in_valid && io_in_ready)
        exp_q.push_back({io_in_bits_typ ? ref_s2d(io_in_bits_src) : ref_d2s(io_in_bits_src, io_in_bits_rm), io_in_bits_tag});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    io_in_valid = 1'b0; io_flush = 1'b0; io_out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick(); n++;
    end
    check_value("drain_empty", 80'(exp_q.size()), 80'(0));
  endtask

  logic [63:0] d_src [13] = '{64'h3FF0000000000000, 64'h47F0000000000000, 64'h47F0000000000000,
                              64'h3690000000000000, 64'h3690000000000000, 64'h7FF0000000000001,
                              64'h000000003F800000, 64'hFFFFFFFF3F800000, 64'h47F0000000000000,
                              64'hC7F0000000000000, 64'hC7F0000000000000, 64'h3690000000000000,
                              64'h380FFFFFF0000000};
  logic        d_typ [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0]  d_rm  [13] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd5, 3'd0};
  logic [68:0] d_exp [13] = '{{64'hFFFFFFFF3F800000, 5'h00}, {64'hFFFFFFFF7F800000, 5'h05},
                              {64'hFFFFFFFF7F7FFFFF, 5'h05}, {64'hFFFFFFFF00000000, 5'h03},
                              {64'hFFFFFFFF00000001, 5'h03}, {64'hFFFFFFFF7FC00000, 5'h10},
                              {64'h7FF8000000000000, 5'h00}, {64'h3FF0000000000000, 5'h00},
                              {64'hFFFFFFFF7F7FFFFF, 5'h05}, {64'hFFFFFFFFFF800000, 5'h05},
                              {64'hFFFFFFFFFF7FFFFF, 5'h05}, {64'hFFFFFFFF00000000, 5'h03},
                              {64'hFFFFFFFF00800000, 5'h01}};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, cyc, i;
    logic acc;
    logic [TW-1:0] tag_cnt;
    reset = 1'b1; io_flush = 1'b0; io_in_valid = 1'b0; io_in_bits_src = 64'd0;
    io_in_bits_typ = 1'b0; io_in_bits_rm = 3'd0; io_in_bits_tag = '0; io_out_ready = 1'b1;
    #3;
    check_value("reset_out_valid", 80'(io_out_valid), 80'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check_value("post_reset_in_ready", 80'(io_in_ready), 80'(1));
    check_value("post_reset_out_valid", 80'(io_out_valid), 80'(0));

    // Directed corner vectors, one at a time through an empty pipe.
    for (int v = 0; v < 13; v++) begin
      io_in_valid = 1'b1; io_in_bits_src = d_src[v]; io_in_bits_typ = d_typ[v];
      io_in_bits_rm = d_rm[v]; io_in_bits_tag = 8'(200 + v);
      tick();
      io_in_valid = 1'b0;
      n = 1;
      while (n < 10) begin
        @(negedge clock);
        if (io_out_valid) break;
        tick(); n++;
      end
      check_value("latency", 80'(n), 80'(LAT));
      check_value("directed", 80'({io_out_bits_result, io_out_bits_fflags}), 80'(d_exp[v]));
      tick();
    end
    drain();

    // Backpressure: 8 ops, tags 0..7, consumer stalled for 5 cycles.
    out_log.delete();
    i = 0; cyc = 0;
    while (i < 8 && cyc < 40) begin
      io_in_valid = 1'b1; io_in_bits_typ = 1'b0; io_in_bits_src = rand_d();
      io_in_bits_rm = 3'($urandom_range(0, 4)); io_in_bits_tag = 8'(i);
      io_out_ready = !(cyc >= 3 && cyc < 8);
      @(negedge clock);
      if (cyc == 7) check_value("in_ready_drop", 80'(io_in_ready), 80'(0));
      acc = io_in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    drain();
    check_value("bp_count", 80'(out_log.size()), 80'(8));
    for (int j = 0; j < 8 && j < out_log.size(); j++)
      check_value("bp_order", 80'(out_log[j]), 80'(j));

    // Flush with a simultaneous input handshake.
    for (int j = 0; j < 3; j++) begin
      io_in_valid = 1'b1; io_in_bits_typ = 1'b1; io_in_bits_src = rand_s();
      io_in_bits_tag = 8'(50 + j); tick();
    end
    io_flush = 1'b1; io_in_bits_tag = 8'(99);
    @(negedge clock);
    check_value("flush_in_ready", 80'(io_in_ready), 80'(1));
    tick();
    io_flush = 1'b0; io_in_valid = 1'b0;
    @(negedge clock);
    check_value("flush_out_valid", 80'(io_out_valid), 80'(0));
    repeat (5) tick();

    // Asynchronous reset mid-stream.
    for (int j = 0; j < 4; j++) begin
      io_in_valid = 1'b1; io_in_bits_typ = 1'b0; io_in_bits_src = rand_d();
      io_in_bits_tag = 8'(60 + j); tick();
    end
    check_value("pre_reset_valid", 80'(io_out_valid), 80'(1));
    #2 reset = 1'b1;
    #1 check_value("async_reset", 80'(io_out_valid), 80'(0));
    io_in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1 check_value("reset_release_ready", 80'(io_in_ready), 80'(1));
    tick();

    // Random traffic with random stalls and occasional flushes.
    tag_cnt = '0;
    for (int c = 0; c < 800; c++) begin
      io_in_valid = ($urandom_range(0, 3) != 0);
      io_in_bits_typ = 1'($urandom_range(0, 1));
      io_in_bits_src = io_in_bits_typ ? rand_s() : rand_d();
      io_in_bits_rm = 3'($urandom_range(0, 7));
      io_in_bits_tag = tag_cnt;
      io_out_ready = ($urandom_range(0, 3) != 0);
      io_flush = ($urandom_range(0, 39) == 0);
      @(negedge clock);
      acc = io_in_valid && io_in_ready;
      tick();
      if (acc) tag_cnt++;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
